alu_seq_core: RTL

//  Registered, parametrised ALU for the CPU execute stage. Owns a persistent

---
 rtl/alu_pkg.sv | 92 +++++++++
 rtl/alu_shift_seq.sv | 64 ++++++
 rtl/alu_seq_core.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, flag bit positions, FSM states.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package alu_pkg;

  // Primary opcodes
  localparam logic [3:0] OPC_RR    = 4'b0000;  // register-register, op selected by opext
  localparam logic [3:0] OPC_ADDI  = 4'b0101;
  localparam logic [3:0] OPC_ADDUI = 4'b0110;
  localparam logic [3:0] OPC_ADDCI = 4'b0111;
  localparam logic [3:0] OPC_SHIFT = 4'b1000;
  localparam logic [3:0] OPC_SUBI  = 4'b1001;
  localparam logic [3:0] OPC_EXT   = 4'b1010;  // extended group, op selected by opext
  localparam logic [3:0] OPC_CMPI  = 4'b1011;

  // opext values under OPC_RR
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;

  // opext values under OPC_SHIFT and OPC_EXT
  localparam logic [3:0] EXT_LSH    = 4'b0100;
  localparam logic [3:0] EXT_ASH    = 4'b0001;
  localparam logic [3:0] EXT_NOT    = 4'b0011;
  localparam logic [3:0] EXT_ADDCU  = 4'b0101;
  localparam logic [3:0] EXT_ADDCUI = 4'b0110;

  // Flag register bit positions {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [3:0] {
    K_ADD, K_ADDU, K_ADDC, K_ADDCU, K_SUB, K_CMP,
    K_AND, K_OR, K_XOR, K_NOT, K_LSH, K_ASH, K_BAD
  } op_kind_t;

  // Collapse register and immediate forms onto one operation kind.
  function automatic op_kind_t decode_op(input logic [3:0] opc, input logic [3:0] ext);
    op_kind_t k;
    k = K_BAD;
    case (opc)
      OPC_RR: begin
        case (ext)
          EXT_AND:  k = K_AND;
          EXT_OR:   k = K_OR;
          EXT_XOR:  k = K_XOR;
          EXT_ADD:  k = K_ADD;
          EXT_ADDU: k = K_ADDU;
          EXT_ADDC: k = K_ADDC;
          EXT_SUB:  k = K_SUB;
          EXT_CMP:  k = K_CMP;
          default:  k = K_BAD;
        endcase
      end
      OPC_ADDI:  k = K_ADD;
      OPC_ADDUI: k = K_ADDU;
      OPC_ADDCI: k = K_ADDC;
      OPC_SUBI:  k = K_SUB;
      OPC_CMPI:  k = K_CMP;
      OPC_SHIFT: begin
        // LSH register form, or LSHI with the immediate sign in opext[0]
        if (ext == EXT_LSH || ext[3:1] == 3'b000) k = K_LSH;
        else k = K_BAD;
      end
      OPC_EXT: begin
        case (ext)
          EXT_ASH:    k = K_ASH;
          EXT_NOT:    k = K_NOT;
          EXT_ADDCU:  k = K_ADDCU;
          EXT_ADDCUI: k = K_ADDCU;
          default:    k = K_BAD;
        endcase
      end
      default: k = K_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative shifter: one bit position per cycle, left for positive amounts, right for negative.
// Latency: min(|amount|,WIDTH) cycles after start; done marks the final step, dout is its value.
// Backpressure: none; the owner must not pulse start while busy.
module alu_shift_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   val;
  logic [CNT_W-1:0]   cnt;
  logic               left;
  logic               arith_q;
  logic [SHAMT_W-1:0] mag;
  logic [CNT_W-1:0]   cnt_init;
  logic [WIDTH-1:0]   step;

  // Magnitude of the signed amount, clamped so oversized shifts cost WIDTH cycles at most.
  always_comb begin
    mag = amount[SHAMT_W-1] ? -amount : amount;
    if (int'(mag) >= WIDTH) cnt_init = CNT_W'(WIDTH);
    else cnt_init = CNT_W'(mag);
  end

  // One-bit shift of the held value; right shifts fill with the MSB only in arithmetic mode.
  always_comb begin
    if (left) step = {val[WIDTH-2:0], 1'b0};
    else step = {arith_q & val[WIDTH-1], val[WIDTH-1:1]};
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));
  assign dout = step;

  // Load on start, then advance one bit and count down until the budget is spent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val     <= '0;
      cnt     <= '0;
      left    <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      val     <= din;
      cnt     <= cnt_init;
      left    <= ~amount[SHAMT_W-1];
      arith_q <= arith;
    end else if (busy) begin
      val <= step;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered execute-stage ALU with a persistent CLFZN flag register and iterative shifts.
// Latency: 2 cycles accept->out_valid inclusive; nonzero shifts take |n|+2.
// Backpressure: in_ready high only when idle; in_valid while busy is left unconsumed.
module alu_seq_core import alu_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       clfzn
);

  logic [1:0]       state;
  op_kind_t         kind;
  logic             is_shift;
  logic             accept;
  logic             sub;
  logic [WIDTH-1:0] bop;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf_add;
  logic             ovf_sub;
  logic             sum_zero;
  logic [WIDTH-1:0] res_nxt;
  logic [4:0]       flg_nxt;
  logic             sh_busy;
  logic             sh_done;
  logic [WIDTH-1:0] sh_dout;

  assign kind      = decode_op(opcode, opext);
  // A zero shift amount needs no iteration and completes like any single-cycle op.
  assign is_shift  = (kind == K_LSH || kind == K_ASH) && (b[SHAMT_W-1:0] != '0);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  alu_shift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_shift),
    .din    (a),
    .amount (b[SHAMT_W-1:0]),
    .arith  (kind == K_ASH),
    .busy   (sh_busy),
    .done   (sh_done),
    .dout   (sh_dout)
  );

  // Shared WIDTH+1 adder: subtract as a + ~b + 1, carry-in from the stored C flag for ADDC forms.
  always_comb begin
    sub      = (kind == K_SUB) || (kind == K_CMP);
    bop      = sub ? ~b : b;
    cin      = sub ? 1'b1 : ((kind == K_ADDC || kind == K_ADDCU) ? clfzn[FLAG_C] : 1'b0);
    sum      = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
    ovf_add  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    ovf_sub  = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sum_zero = (sum[WIDTH-1:0] == '0);
  end

  // Per-op result and flag update; anything not written keeps its registered value.
  always_comb begin
    res_nxt = result;
    flg_nxt = clfzn;
    case (kind)
      K_ADD, K_ADDC: begin
        res_nxt         = sum[WIDTH-1:0];
        flg_nxt[FLAG_C] = sum[WIDTH];
        flg_nxt[FLAG_F] = ovf_add;
        flg_nxt[FLAG_Z] = sum_zero;
      end
      K_ADDU, K_ADDCU: begin
        res_nxt         = sum[WIDTH-1:0];
        flg_nxt[FLAG_C] = sum[WIDTH];
        flg_nxt[FLAG_Z] = sum_zero;
      end
      K_SUB: begin
        res_nxt         = sum[WIDTH-1:0];
        flg_nxt[FLAG_C] = ~sum[WIDTH];
        flg_nxt[FLAG_F] = ovf_sub;
        flg_nxt[FLAG_Z] = sum_zero;
      end
      K_CMP: begin
        flg_nxt[FLAG_C] = ~sum[WIDTH];
        flg_nxt[FLAG_Z] = (a == b);
        flg_nxt[FLAG_L] = (b < a);
        flg_nxt[FLAG_N] = ($signed(b) < $signed(a));
      end
      K_AND:        res_nxt = a & b;
      K_OR:         res_nxt = a | b;
      K_XOR:        res_nxt = a ^ b;
      K_NOT:        res_nxt = ~a;
      K_LSH, K_ASH: res_nxt = a;
      default:      res_nxt = '0;
    endcase
  end

  // Control FSM: capture the combinational result on accept, or the shifter's last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
      clfzn  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift) begin
              state <= ST_SHIFT;
            end else begin
              state  <= ST_DONE;
              result <= res_nxt;
              clfzn  <= flg_nxt;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            result <= sh_dout;
            state  <= ST_DONE;
          end else if (!sh_busy) begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
